// File: rtl/riscv_cache_types_pkg.sv
// Shared cache types: replacement policy encoding, replacement config/stats records
// and tree-PLRU helpers sized for up to 16 ways.
package riscv_cache_types_pkg;

   typedef enum logic [1:0] {
      POL_LRU    = 2'd0,
      POL_RANDOM = 2'd1,
      POL_FIFO   = 2'd2,
      POL_PLRU   = 2'd3
   } replacement_policy_e;

   localparam int unsigned PLRU_MAX_W   = 15;
   localparam int unsigned PLRU_MAX_LVL = 4;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;

   typedef struct packed {
      logic [31:0] ways;
      logic [31:0] sets;
   } repl_cfg_t;

   typedef struct packed {
      logic [31:0] victims;
      logic [31:0] inv_picks;
   } repl_stats_t;

   function automatic int unsigned plru_levels(input int unsigned ways);
      int unsigned lv;
      lv = 0;
      for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
         if ((32'd2 << l) <= ways) lv = l + 1;
      end
      return lv;
   endfunction

   // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bit 1 = go right.
   function automatic logic [3:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                              input int unsigned ways);
      logic [3:0] node;
      logic [3:0] way;
      int unsigned lv;
      node = '0;
      way  = '0;
      lv   = plru_levels(ways);
      for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
         if (l < lv) begin
            way  = {way[2:0], bits[node]};
            node = {node[2:0], 1'b0} + 4'd1 + {3'b000, bits[node]};
         end
      end
      return way;
   endfunction

   function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] bits,
                                                         input logic [3:0] way,
                                                         input int unsigned ways);
      logic [PLRU_MAX_W-1:0] r;
      logic [3:0] node;
      logic b;
      int unsigned lv;
      r    = bits;
      node = '0;
      lv   = plru_levels(ways);
      for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
         if (l < lv) begin
            b       = way[2'(lv - 1 - l)];
            r[node] = ~b;
            node    = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/riscv_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11, loaded with seed_i on reset.
module riscv_lfsr16 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic [15:0] seed_i,
   output logic [15:0] q_o
);

   logic feedback;

   assign feedback = q_o[0] ^ q_o[2] ^ q_o[3] ^ q_o[5];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       q_o <= seed_i;
      else if (enable_i) q_o <= {feedback, q_o[15:1]};
   end

endmodule

// File: rtl/riscv_cache_repl_unit.sv
// N-way victim selection with run-time LRU/RANDOM/FIFO/PLRU and a set-by-set init sweep.
// Optional victim statistics counters when RISCV_CACHE_REPL_STATS_EN is defined.
module riscv_cache_repl_unit
   import riscv_cache_types_pkg::*;
#(
   parameter  int unsigned WAYS  = 4,
   parameter  int unsigned SETS  = 64,
   localparam int unsigned SET_W = $clog2(SETS),
   localparam int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  replacement_policy_e policy_i,
   input  logic                flush_i,
   output logic                init_busy_o,
   input  logic                touch_valid_i,
   input  logic [SET_W-1:0]    touch_set_i,
   input  logic [WAY_W-1:0]    touch_way_i,
   input  logic                fill_valid_i,
   input  logic [SET_W-1:0]    fill_set_i,
   input  logic [WAY_W-1:0]    fill_way_i,
   input  logic                victim_req_i,
   output logic                victim_ready_o,
   input  logic [SET_W-1:0]    victim_set_i,
   input  logic [WAYS-1:0]     valid_ways_i,
   output logic                victim_valid_o,
   output logic [WAY_W-1:0]    victim_way_o,
   output logic [31:0]         stats_victims_o,
   output logic [31:0]         stats_inv_pick_o
);

   localparam repl_cfg_t        CFG      = '{ways: 32'(WAYS), sets: 32'(SETS)};
   localparam int unsigned      PLRU_W   = CFG.ways - 1;
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(CFG.sets - 1);

   typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;
   typedef enum logic {ST_SWEEP, ST_IDLE} sweep_state_e;

   sweep_state_e        state_q, state_d;
   logic [SET_W-1:0]    sweep_set_q, sweep_set_d;
   replacement_policy_e policy_q, policy_d;
   logic                boot_q;
   logic                restart;
   logic                accept;
   logic [15:0]         lfsr_q;
   logic                unused_lfsr;

   ages_t               lru_q  [SETS];
   logic [PLRU_W-1:0]   plru_q [SETS];
   logic [WAY_W-1:0]    fifo_q [SETS];

   ages_t               lru_init, lru_row, t_lru, f_lru;
   logic [PLRU_W-1:0]   t_plru, f_plru;
   logic [WAY_W-1:0]    f_fifo;
   logic                same_set;
   logic                inv_any;
   logic [WAY_W-1:0]    inv_way, lru_way, pol_way, victim_way_c;

   function automatic ages_t lru_touch(input ages_t a, input logic [WAY_W-1:0] w);
      ages_t r;
      r = a;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (a[WAY_W'(i)] < a[w]) r[WAY_W'(i)] = a[WAY_W'(i)] + WAY_W'(1);
      end
      r[w] = '0;
      return r;
   endfunction

   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                    input logic [WAY_W-1:0]  w);
      return PLRU_W'(plru_update(PLRU_MAX_W'(b), 4'(w), WAYS));
   endfunction

   riscv_lfsr16 u_lfsr (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .enable_i (1'b1),
      .seed_i   (LFSR_SEED),
      .q_o      (lfsr_q)
   );

   assign unused_lfsr    = ^lfsr_q[15:WAY_W];
   assign init_busy_o    = (state_q == ST_SWEEP);
   assign victim_ready_o = ~init_busy_o;
   assign accept         = victim_req_i & victim_ready_o;

   // Sweep control; the first cycle after reset only captures policy_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_SWEEP;
         sweep_set_q <= '0;
         policy_q    <= POL_LRU;
         boot_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         sweep_set_q <= sweep_set_d;
         policy_q    <= policy_d;
         boot_q      <= 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      sweep_set_d = sweep_set_q;
      policy_d    = policy_q;
      restart     = 1'b0;
      if (boot_q) begin
         policy_d = policy_i;
      end else if (flush_i || (policy_i != policy_q)) begin
         restart  = 1'b1;
         policy_d = policy_i;
      end
      unique case (state_q)
         ST_SWEEP: begin
            if (restart) begin
               sweep_set_d = '0;
            end else if (sweep_set_q == LAST_SET) begin
               state_d     = ST_IDLE;
               sweep_set_d = '0;
            end else begin
               sweep_set_d = sweep_set_q + SET_W'(1);
            end
         end
         ST_IDLE: begin
            if (restart) begin
               state_d     = ST_SWEEP;
               sweep_set_d = '0;
            end
         end
         default: state_d = ST_SWEEP;
      endcase
   end

   // Victim selection reads the stored state only (no same-cycle bypass).
   always_comb begin
      lru_row = lru_q[victim_set_i];
      inv_any = 1'b0;
      inv_way = '0;
      lru_way = '0;
      pol_way = '0;
      for (int i = int'(WAYS) - 1; i >= 0; i--) begin
         if (!valid_ways_i[WAY_W'(i)]) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(i);
         end
      end
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (lru_row[WAY_W'(i)] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(i);
      end
      unique case (policy_q)
         POL_LRU:    pol_way = lru_way;
         POL_PLRU:   pol_way = WAY_W'(plru_victim(PLRU_MAX_W'(plru_q[victim_set_i]), WAYS));
         POL_FIFO:   pol_way = fifo_q[victim_set_i];
         POL_RANDOM: pol_way = lfsr_q[WAY_W-1:0];
         default:    pol_way = '0;
      endcase
      victim_way_c = inv_any ? inv_way : pol_way;
   end

   // Touch is applied first; a fill to the same set builds on the touched row.
   always_comb begin
      for (int unsigned i = 0; i < WAYS; i++) lru_init[WAY_W'(i)] = WAY_W'(i);
      same_set = touch_valid_i && (touch_set_i == fill_set_i);
      t_lru    = lru_touch(lru_q[touch_set_i], touch_way_i);
      t_plru   = plru_touch(plru_q[touch_set_i], touch_way_i);
      f_lru    = lru_touch(same_set ? t_lru : lru_q[fill_set_i], fill_way_i);
      f_plru   = plru_touch(same_set ? t_plru : plru_q[fill_set_i], fill_way_i);
      f_fifo   = fill_way_i + WAY_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (init_busy_o) begin
         lru_q[sweep_set_q]  <= lru_init;
         plru_q[sweep_set_q] <= '0;
         fifo_q[sweep_set_q] <= '0;
      end else begin
         if (touch_valid_i) begin
            if (policy_q == POL_LRU)  lru_q[touch_set_i]  <= t_lru;
            if (policy_q == POL_PLRU) plru_q[touch_set_i] <= t_plru;
         end
         if (fill_valid_i) begin
            if (policy_q == POL_LRU)  lru_q[fill_set_i]  <= f_lru;
            if (policy_q == POL_PLRU) plru_q[fill_set_i] <= f_plru;
            if (policy_q == POL_FIFO) fifo_q[fill_set_i] <= f_fifo;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         victim_valid_o <= 1'b0;
         victim_way_o   <= '0;
      end else begin
         victim_valid_o <= accept;
         if (accept) victim_way_o <= victim_way_c;
      end
   end

`ifdef RISCV_CACHE_REPL_STATS_EN
   repl_stats_t stats_q;

   // Saturating counters; a flush clears them, a policy change does not.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stats_q <= '0;
      end else if (flush_i) begin
         stats_q <= '0;
      end else if (accept) begin
         if (stats_q.victims != '1) stats_q.victims <= stats_q.victims + 32'd1;
         if (inv_any && (stats_q.inv_picks != '1)) stats_q.inv_picks <= stats_q.inv_picks + 32'd1;
      end
   end

   assign stats_victims_o  = stats_q.victims;
   assign stats_inv_pick_o = stats_q.inv_picks;
`else
   assign stats_victims_o  = 32'h0;
   assign stats_inv_pick_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_cache_repl_unit.sv
// Directed + randomized bench for riscv_cache_repl_unit against a recency-list / tree / pointer model.
module tb_riscv_cache_repl_unit;
   import riscv_cache_types_pkg::*;

   localparam int unsigned WAYS  = 4;
   localparam int unsigned SETS  = 64;
   localparam int unsigned SET_W = 6;
   localparam int unsigned WAY_W = 2;
   localparam int unsigned LVL   = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   replacement_policy_e policy;
   logic                flush;
   logic                init_busy;
   logic                touch_valid, fill_valid, victim_req;
   logic [SET_W-1:0]    touch_set, fill_set, victim_set;
   logic [WAY_W-1:0]    touch_way, fill_way;
   logic                victim_ready, victim_valid;
   logic [WAYS-1:0]     valid_ways;
   logic [WAY_W-1:0]    victim_way;
   logic [31:0]         stats_victims, stats_inv_pick;

   always #5 clk = ~clk;

   riscv_cache_repl_unit #(.WAYS(WAYS), .SETS(SETS)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .policy_i         (policy),
      .flush_i          (flush),
      .init_busy_o      (init_busy),
      .touch_valid_i    (touch_valid),
      .touch_set_i      (touch_set),
      .touch_way_i      (touch_way),
      .fill_valid_i     (fill_valid),
      .fill_set_i       (fill_set),
      .fill_way_i       (fill_way),
      .victim_req_i     (victim_req),
      .victim_ready_o   (victim_ready),
      .victim_set_i     (victim_set),
      .valid_ways_i     (valid_ways),
      .victim_valid_o   (victim_valid),
      .victim_way_o     (victim_way),
      .stats_victims_o  (stats_victims),
      .stats_inv_pick_o (stats_inv_pick)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: recency list (front = most recent), PLRU node bits, FIFO pointers.
   int                  rec    [SETS][$];
   bit                  plru_m [SETS][WAYS-1];
   int                  fifo_m [SETS];
   int                  sweep_left;
   replacement_policy_e m_pol;
   logic [15:0]         m_lfsr;
   int unsigned         m_vic, m_inv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      for (int s = 0; s < SETS; s++) begin
         rec[s] = {};
         for (int w = 0; w < WAYS; w++) rec[s].push_back(w);
         for (int n = 0; n < WAYS - 1; n++) plru_m[s][n] = 1'b0;
         fifo_m[s] = 0;
      end
   endtask

   function automatic int model_victim(input int s, input logic [WAYS-1:0] vw);
      int n, w;
      for (int i = 0; i < WAYS; i++) if (!vw[i]) return i;
      case (m_pol)
         POL_LRU:  return rec[s][$];
         POL_FIFO: return fifo_m[s];
         POL_PLRU: begin
            n = 0; w = 0;
            for (int l = 0; l < LVL; l++) begin
               w = w * 2 + int'(plru_m[s][n]);
               n = 2 * n + 1 + int'(plru_m[s][n]);
            end
            return w;
         end
         default:  return int'(m_lfsr) % WAYS;
      endcase
   endfunction

   task automatic model_use(input int s, input int w);
      int n, b;
      if (m_pol == POL_LRU) begin
         for (int i = 0; i < rec[s].size(); i++) begin
            if (rec[s][i] == w) begin
               rec[s].delete(i);
               break;
            end
         end
         rec[s].push_front(w);
      end else if (m_pol == POL_PLRU) begin
         n = 0;
         for (int l = 0; l < LVL; l++) begin
            b = (w >> (LVL - 1 - l)) & 1;
            plru_m[s][n] = (b == 0);
            n = 2 * n + 1 + b;
         end
      end
   endtask

   // One clock: drive inputs, predict, advance, then check everything observable.
   task automatic step(input bit tv, input int ts, input int tw, input bit fv, input int fs,
                       input int fw, input bit rv, input int rs, input logic [WAYS-1:0] vw,
                       input bit fl, output int got);
      bit acc, restart;
      int exp_w;
      touch_valid = tv; touch_set = SET_W'(ts); touch_way = WAY_W'(tw);
      fill_valid  = fv; fill_set  = SET_W'(fs); fill_way  = WAY_W'(fw);
      victim_req  = rv; victim_set = SET_W'(rs); valid_ways = vw;
      flush       = fl;
      acc   = rv && (sweep_left == 0);
      exp_w = acc ? model_victim(rs, vw) : 0;
      if (sweep_left == 0) begin
         if (tv) model_use(ts, tw);
         if (fv) begin
            if (m_pol == POL_FIFO) fifo_m[fs] = (fw + 1) % WAYS;
            else model_use(fs, fw);
         end
      end
      if (acc) m_vic++;
      if (acc && (vw != '1)) m_inv++;
      if (fl) begin m_vic = 0; m_inv = 0; end
      restart = fl || (policy != m_pol);
      if (restart) begin
         m_pol = policy;
         sweep_left = SETS;
         model_init();
      end else if (sweep_left > 0) begin
         sweep_left--;
      end
      @(posedge clk); #1;
      got = int'(victim_way);
      check("victim_valid", victim_valid, acc);
      if (acc) check("victim_way", victim_way, exp_w);
      check("init_busy", init_busy, sweep_left > 0);
      check("victim_ready", victim_ready, sweep_left == 0);
`ifdef RISCV_CACHE_REPL_STATS_EN
      check("stats_victims", stats_victims, m_vic);
      check("stats_inv_pick", stats_inv_pick, m_inv);
`else
      check("stats_victims_tied", stats_victims, 0);
      check("stats_inv_pick_tied", stats_inv_pick, 0);
`endif
      touch_valid = 1'b0; fill_valid = 1'b0; victim_req = 1'b0; flush = 1'b0;
   endtask

   task automatic idle();
      int g;
      step(0, 0, 0, 0, 0, 0, 0, 0, '1, 0, g);
   endtask

   task automatic touch(input int s, input int w);
      int g;
      step(1, s, w, 0, 0, 0, 0, 0, '1, 0, g);
   endtask

   task automatic fill(input int s, input int w);
      int g;
      step(0, 0, 0, 1, s, w, 0, 0, '1, 0, g);
   endtask

   task automatic req(input int s, input logic [WAYS-1:0] vw, output int got);
      step(0, 0, 0, 0, 0, 0, 1, s, vw, 0, got);
   endtask

   // Counts busy cycles until the sweep ends, optionally hammering requests meanwhile.
   task automatic wait_idle(input bit with_req, output int n);
      int g;
      n = 0;
      while (init_busy && n < 200) begin
         step(0, 0, 0, 0, 0, 0, with_req, int'($urandom_range(0, SETS - 1)), '1, 0, g);
         n++;
      end
   endtask

   function automatic int rand_set();
      int r;
      r = int'($urandom_range(0, 3));
      return (r < 2) ? r : int'(SETS) - 4 + r;
   endfunction

   initial begin
      int got, n;
      replacement_policy_e pols [4];
      pols = '{POL_LRU, POL_RANDOM, POL_FIFO, POL_PLRU};

      rst_n = 1'b0; policy = POL_LRU; flush = 1'b0;
      touch_valid = 1'b0; fill_valid = 1'b0; victim_req = 1'b0;
      touch_set = '0; touch_way = '0; fill_set = '0; fill_way = '0;
      victim_set = '0; valid_ways = '1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_init_busy", init_busy, 1);
      check("reset_victim_ready", victim_ready, 0);
      check("reset_victim_valid", victim_valid, 0);
      check("reset_victim_way", victim_way, 0);
      check("reset_stats_victims", stats_victims, 0);
      check("reset_stats_inv", stats_inv_pick, 0);

      rst_n = 1'b1;
      m_pol = POL_LRU; sweep_left = SETS; m_vic = 0; m_inv = 0;
      model_init();
      wait_idle(0, n);
      check("sweep_len_reset", n, 64);

      // LRU, set 5
      touch(5, 0); touch(5, 1); touch(5, 2); touch(5, 3);
      req(5, '1, got); check("lru_after_0123", got, 0);
      touch(5, 0);
      req(5, '1, got); check("lru_after_touch0", got, 1);

      // FIFO, set 9
      policy = POL_FIFO; idle();
      wait_idle(0, n); check("sweep_len_fifo", n, 64);
      fill(9, 0); fill(9, 1);
      req(9, '1, got); check("fifo_after_01", got, 2);
      fill(9, 3);
      req(9, '1, got); check("fifo_wrap", got, 0);

      // PLRU, set 3
      policy = POL_PLRU; idle();
      wait_idle(0, n); check("sweep_len_plru", n, 64);
      touch(3, 0);
      req(3, '1, got); check("plru_after_t0", got, 2);
      touch(3, 2);
      req(3, '1, got); check("plru_after_t2", got, 1);

      // Invalid-way override and read-before-write
      req(3, 4'b1011, got); check("inv_override", got, 2);
      step(1, 3, 1, 0, 0, 0, 1, 3, '1, 0, got); check("pre_touch_victim", got, 1);
      req(3, '1, got); check("post_touch_victim", got, 3);

      // Policy change under traffic
      step(1, 7, 1, 0, 0, 0, 1, 7, '1, 0, got);
      policy = POL_LRU;
      step(0, 0, 0, 0, 0, 0, 1, 12, '1, 0, got);
      wait_idle(1, n); check("sweep_len_traffic", n, 64);
      req(5, '1, got); check("lru_reinit", got, 3);
      touch(5, 3);
      req(5, '1, got); check("lru_reinit_touch3", got, 2);

      // Flush clears stats and restarts the sweep
      step(0, 0, 0, 0, 0, 0, 0, 0, '1, 1, got);
      check("flush_stats_victims", stats_victims, 0);
      wait_idle(0, n); check("sweep_len_flush", n, 64);

      // Randomized traffic per policy on a few boundary sets
      foreach (pols[p]) begin
         if (policy == pols[p]) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, '1, 1, got);
         end else begin
            policy = pols[p];
            idle();
         end
         wait_idle(0, n); check("sweep_len_rand", n, 64);
         for (int k = 0; k < 150; k++) begin
            step(1'($urandom_range(0, 1)), rand_set(), int'($urandom_range(0, WAYS - 1)),
                 1'($urandom_range(0, 1)), rand_set(), int'($urandom_range(0, WAYS - 1)),
                 1'($urandom_range(0, 3) != 0), rand_set(),
                 ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1, 0, got);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
